// File: rtl/arbitro_buffer_rr.sv
// arbitro_buffer_rr: round-robin write arbiter with per-owner quantum, consumer
// read handshake and flush/drain sequencer in front of a circular buffer.
// Optional build macro: ARB_STATS_EN (16-bit saturating full-stall counter).
module arbitro_buffer_rr #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] dato_req_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     insercion_o,
  output logic [WIDTH-1:0]         dato_o,
  output logic                     delecion_o,
  input  logic                     llena_i,
  input  logic                     vacia_i,
  input  logic [WIDTH-1:0]         dato_buf_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         dato_cons_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic                     flush_done_o,
  output logic [1:0]               estado_o,
  output logic [15:0]              stall_cnt_o
);

  // state   | meaning
  // IDLE    | no owner; arbitrate from rr_ptr
  // SERVE   | owner holds the write port for up to QUANTUM insertions
  // FLUSH   | drain buffer until empty, then pulse flush_done_o
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(QUANTUM + 1);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SERVE = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;

  logic [1:0]    r_estado, w_estado_n;
  logic [PW-1:0] r_rr_ptr, w_rr_ptr_n;
  logic [PW-1:0] r_owner, w_owner_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          w_grant;
  logic [PW-1:0] w_grant_idx;
  logic [PW-1:0] w_owner_inc;
  logic [PW:0]   w_arb_idle, w_arb_rel;
  logic [15:0]   w_stall;

  // explicit wrap so non-power-of-two NUM_REQ stays in range
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // returns {found, index} of first requester scanning upward from start
  function automatic logic [PW:0] f_arb(input logic [NUM_REQ-1:0] req,
                                        input logic [PW-1:0] start);
    logic [PW:0] res;
    int k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(start) + i) % NUM_REQ;
      if (req[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction

  assign w_owner_inc = f_inc(r_owner);
  assign w_arb_idle  = f_arb(req_i, r_rr_ptr);
  assign w_arb_rel   = f_arb(req_i, w_owner_inc);

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_estado <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_n;
      r_rr_ptr <= w_rr_ptr_n;
      r_owner  <= w_owner_n;
      r_cnt    <= w_cnt_n;
    end
  end

  // next-state and grant decision
  always_comb begin
    w_estado_n  = r_estado;
    w_rr_ptr_n  = r_rr_ptr;
    w_owner_n   = r_owner;
    w_cnt_n     = r_cnt;
    w_grant     = 1'b0;
    w_grant_idx = r_owner;
    case (r_estado)
      S_IDLE: begin
        if (flush_i) begin
          w_estado_n = S_FLUSH;
        end else if (w_arb_idle[PW] && !llena_i) begin
          w_grant     = 1'b1;
          w_grant_idx = w_arb_idle[PW-1:0];
          w_owner_n   = w_arb_idle[PW-1:0];
          w_cnt_n     = CW'(1);
          w_estado_n  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (flush_i) begin
          w_estado_n = S_FLUSH;
          w_rr_ptr_n = w_owner_inc;
        end else if (req_i[r_owner] && (r_cnt < CW'(QUANTUM))) begin
          // a full buffer freezes the owner without spending quantum
          if (!llena_i) begin
            w_grant     = 1'b1;
            w_grant_idx = r_owner;
            w_cnt_n     = r_cnt + 1'b1;
          end
        end else begin
          // release and hand over in the same cycle to avoid an idle gap
          w_rr_ptr_n = w_owner_inc;
          if (w_arb_rel[PW] && !llena_i) begin
            w_grant     = 1'b1;
            w_grant_idx = w_arb_rel[PW-1:0];
            w_owner_n   = w_arb_rel[PW-1:0];
            w_cnt_n     = CW'(1);
          end else begin
            w_estado_n = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (vacia_i) w_estado_n = S_IDLE;
      end
      default: w_estado_n = S_IDLE;
    endcase
  end

  // outputs, all held at zero while reset is asserted
  always_comb begin
    ack_o        = '0;
    insercion_o  = 1'b0;
    dato_o       = '0;
    delecion_o   = 1'b0;
    valid_o      = 1'b0;
    dato_cons_o  = '0;
    flush_done_o = 1'b0;
    estado_o     = 2'b00;
    stall_cnt_o  = '0;
    if (rstn_i) begin
      estado_o    = r_estado;
      stall_cnt_o = w_stall;
      if (w_grant) begin
        ack_o       = NUM_REQ'(1) << w_grant_idx;
        insercion_o = 1'b1;
        dato_o      = dato_req_i[w_grant_idx*WIDTH +: WIDTH];
      end
      if (r_estado == S_FLUSH) begin
        delecion_o   = ~vacia_i;
        flush_done_o = vacia_i;
      end else begin
        valid_o     = ~vacia_i;
        dato_cons_o = dato_buf_i;
        delecion_o  = ~vacia_i & ready_i;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_stall;

  // count cycles a producer is blocked by a full buffer, saturating
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stall <= '0;
    end else if ((r_estado != S_FLUSH) && (|req_i) && llena_i && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign w_stall = r_stall;
`else
  assign w_stall = '0;
`endif

endmodule

// File: doc/arbitro_buffer_rr.md
Name: arbitro_buffer_rr

Overview:
Round-robin arbiter and sequencer that shares one circular buffer (insertion/deletion/full/empty interface) between NUM_REQ producers and a single consumer.
- Grants the write port with a per-owner quantum.
- Drives buffer deletions from a valid/ready consumer handshake.
- Provides a flush sequence that drains the buffer.
- Sits directly in front of the buffer instance; the buffer itself is not included.

Parameters:
- WIDTH, 64, data word width.
- NUM_REQ, 4, number of producers (>=2).
- QUANTUM, 4, max consecutive insertions per grant (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  producer k requests an insertion (level).
- dato_req_i  in  NUM_REQ*WIDTH  producer k data at bits [k*WIDTH +: WIDTH].
- ack_o  out  NUM_REQ  one-hot; word of producer k is inserted this cycle.
- insercion_o  out  1  to buffer insertion.
- dato_o  out  WIDTH  to buffer write data.
- delecion_o  out  1  to buffer deletion.
- llena_i  in  1  buffer full.
- vacia_i  in  1  buffer empty.
- dato_buf_i  in  WIDTH  buffer head data.
- valid_o  out  1  head word valid to consumer.
- dato_cons_o  out  WIDTH  head word to consumer.
- ready_i  in  1  consumer accepts head word.
- flush_i  in  1  request drain of the buffer (level, sampled in IDLE/SERVE).
- flush_done_o  out  1  one-cycle pulse when drain completes.
- estado_o  out  2  FSM state: IDLE=00, SERVE=01, FLUSH=10.
- stall_cnt_o  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset (async, rstn_i=0): state IDLE, rr_ptr=0, owner=0, cnt=0. While rstn_i=0 all outputs are forced to 0. Reset mid-operation aborts any grant or flush immediately.
- Write path is combinational from registered state:
  - insercion_o = |ack_o.
  - dato_o = owner word when inserting, else 0.
- Arbitration picks the first k with req_i[k]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
- IDLE:
  - flush_i=1 -> FLUSH; no insertion this cycle.
  - Else if any req and llena_i=0 -> insert from winner k, owner<=k, cnt<=1, go to SERVE.
  - Else stay in IDLE.
- SERVE:
  - flush_i=1 -> FLUSH; no insertion; rr_ptr<=owner+1.
  - Else if req_i[owner]=1 and cnt<QUANTUM: insert when llena_i=0 (cnt++); hold with no insertion when llena_i=1 (cnt unchanged).
  - Else (owner dropped request or cnt==QUANTUM): release. rr_ptr<=owner+1 mod NUM_REQ. In the same cycle, arbitrate from owner+1. A winner with llena_i=0 is inserted immediately (owner<=winner, cnt<=1, stay SERVE); otherwise go to IDLE.
  - QUANTUM=1 means release after every insertion.
- FLUSH:
  - ack_o=0, insercion_o=0, valid_o=0.
  - delecion_o = ~vacia_i.
  - When vacia_i=1: flush_done_o=1 for that cycle, then IDLE. rr_ptr is unchanged.
  - flush_i is ignored while in FLUSH.
- Read path (IDLE/SERVE):
  - valid_o = ~vacia_i, dato_cons_o = dato_buf_i.
  - delecion_o = valid_o & ready_i.
  - Zero-latency handshake: a word is consumed in the cycle valid_o & ready_i are both 1.
- Insertion and deletion in the same cycle are allowed.
- Insertion uses only llena_i, i.e. it stays blocked when the buffer is full even if a deletion occurs in that cycle.
- Producers must hold req_i and data stable until ack_o.
- Counter widths: cnt is $clog2(QUANTUM+1) bits; rr_ptr and owner are $clog2(NUM_REQ) bits with explicit modulo wrap (NUM_REQ need not be a power of two).

Optional Feature:
ARB_STATS_EN
- Defined: stall_cnt_o is a 16-bit saturating counter, reset to 0. It increments every cycle in which state!=FLUSH, |req_i=1 and llena_i=1. It holds at 16'hFFFF.
- Not defined: stall_cnt_o is tied to 0 and no counter logic is built.

Test Plan:
- Reset: rstn_i=0 with req_i=4'b1111 and vacia_i=0 -> all outputs 0, estado_o=00. After release with req_i=0 and vacia_i=1 -> no ack_o, valid_o=0.
- Quantum rotation: req_i=4'b1111 held, llena_i=0, QUANTUM=4 -> ack_o sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001...; insercion_o=1 every cycle.
- Early release: req_i=0001 for 2 cycles, then 0100 -> two acks to producer 0; the next cycle ack_o=0100 with no idle gap; estado_o stays 01.
- Full stall: owner 1 with req_i=0010, llena_i=1 for 5 cycles -> insercion_o=0, cnt frozen, stall_cnt_o=5 (ARB_STATS_EN). Then llena_i=0 -> ack_o=0010 next cycle.
- Flush: vacia_i=0 for 3 cycles then 1, flush_i=1 while req_i=1111 -> estado_o=10, ack_o=0, delecion_o=1 for 3 cycles, flush_done_o single pulse, then IDLE and grant from rr_ptr.
- Consumer: vacia_i=0, dato_buf_i=64'hA5, ready_i=0 -> valid_o=1, delecion_o=0. Then ready_i=1 -> delecion_o=1, dato_cons_o=64'hA5, with a simultaneous insertion allowed.
